// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state names, line levels and default sizing.
// Used by the transmitter, its baud counter and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int DEF_SIZE         = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period cycle counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Ports: clk, rst (sync, high), clear, en in; bit_end strobe out on last cycle.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_end = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= bit_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZE data bits LSB first, optional parity, stop bits.
// Ports: clk, rst (sync, high), tx_start, data_in in; tx, tx_busy, tx_done out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int SIZE         = DEF_SIZE,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_start,
  input  logic [SIZE-1:0] data_in,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int IW = cnt_width(SIZE + 1);
  localparam int CW = cnt_width(CLKS_PER_BIT * STOP_BITS);

  localparam logic [IW-1:0] LAST_IDX  = IW'(SIZE - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_EN    = (PARITY_EN != 0);

  tx_state_e       state_q, state_n;
  logic [SIZE-1:0] sh_q, sh_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic            par_q, par_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            accept;
  logic            bit_end;
  logic            cnt_en;

  assign cnt_en  = (state_q != IDLE);
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .en     (cnt_en),
    .bit_end(bit_end)
  );

  // Outputs are computed for the next state and registered, so tx
  // changes exactly at the bit boundary with no input-to-output path.
  always_comb begin
    state_n = state_q;
    sh_n    = sh_q;
    idx_n   = idx_q;
    par_n   = par_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_n   = IDLE_LEVEL;
        busy_n = 1'b0;
        if (tx_start) begin
          accept  = 1'b1;
          sh_n    = data_in;
          par_n   = (^data_in) ^ PAR_ODD;
          idx_n   = '0;
          state_n = START;
          tx_n    = START_LEVEL;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_n = '0;
            if (PAR_EN) begin
              state_n = PARITY;
              tx_n    = par_q;
            end else begin
              state_n = STOP;
              tx_n    = IDLE_LEVEL;
            end
          end else begin
            idx_n = idx_q + 1'b1;
            sh_n  = sh_q >> 1;
            tx_n  = sh_n[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_n   = '0;
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      idx_q   <= idx_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

endmodule
